// File: rtl/vram_write_scheduler.sv
// Write-port scheduler for the video RAM: clear sweep, brush stamps, host pixels.
// Ports: cclk/rst, clear_req/busy/done, touch_* (valid/ready), host_* (valid/ready), vram_we/addr/din.
module vram_write_scheduler #(
  parameter int X_RES = 480,
  parameter int Y_RES = 272,
  parameter int BITS_PER_PIXEL = 9,
  parameter logic [BITS_PER_PIXEL-1:0] CLEAR_COLOR = 9'h003,
  parameter int BRUSH = 3
) (
  input  logic                      cclk,
  input  logic                      rst,
  input  logic                      clear_req,
  output logic                      clear_busy,
  output logic                      clear_done,
  input  logic                      touch_valid,
  input  logic [8:0]                touch_x,
  input  logic [8:0]                touch_y,
  input  logic [BITS_PER_PIXEL-1:0] touch_color,
  output logic                      touch_ready,
  input  logic                      host_valid,
  input  logic [8:0]                host_x,
  input  logic [8:0]                host_y,
  input  logic [BITS_PER_PIXEL-1:0] host_data,
  output logic                      host_ready,
  output logic                      vram_we,
  output logic [16:0]               vram_addr,
  output logic [BITS_PER_PIXEL-1:0] vram_din
);

  localparam int TOTAL = X_RES * Y_RES;
  localparam int B2 = BRUSH * BRUSH;
  localparam logic signed [10:0] RS = 11'((BRUSH - 1) / 2);
  localparam logic signed [10:0] XR = 11'(X_RES);
  localparam logic signed [10:0] YR = 11'(Y_RES);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_BRUSH} state_t;

  state_t state_q, state_d;
  logic pend_q, pend_d;
  logic [16:0] ca_q, ca_d;
  logic [5:0] cnt_q, cnt_d;
  logic signed [10:0] bx_q, bx_d, by_q, by_d;
  logic signed [10:0] ox_q, ox_d, oy_q, oy_d;
  logic [BITS_PER_PIXEL-1:0] bc_q, bc_d;
  logic we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic [16:0] addr_q, addr_d;
  logic [BITS_PER_PIXEL-1:0] din_q, din_d;

  logic idle, clr_eff, t_go, h_go;
  logic signed [10:0] cur_bx, cur_by, cur_ox, cur_oy;
  logic signed [10:0] nxt_ox, nxt_oy, pix_x, pix_y;
  logic [BITS_PER_PIXEL-1:0] cur_c;
  logic in_rng;
  logic [16:0] pix_addr;

  // pend_q carries the power-up clear out of reset
  assign idle = (state_q == S_IDLE);
  assign clr_eff = clear_req | pend_q;
  assign touch_ready = idle & ~rst & ~clr_eff;
  assign host_ready = touch_ready & ~touch_valid;
  assign t_go = touch_valid & touch_ready;
  assign h_go = host_valid & host_ready;

  // one shared pixel path for brush cells and host writes
  always_comb begin
    if (state_q == S_BRUSH) begin
      cur_bx = bx_q;
      cur_by = by_q;
      cur_ox = ox_q;
      cur_oy = oy_q;
      cur_c = bc_q;
    end else if (touch_valid) begin
      cur_bx = {2'b00, touch_x};
      cur_by = {2'b00, touch_y};
      cur_ox = -RS;
      cur_oy = -RS;
      cur_c = touch_color;
    end else begin
      cur_bx = {2'b00, host_x};
      cur_by = {2'b00, host_y};
      cur_ox = '0;
      cur_oy = '0;
      cur_c = host_data;
    end
  end

  assign pix_x = cur_bx + cur_ox;
  assign pix_y = cur_by + cur_oy;
  assign in_rng = (pix_x >= 0) && (pix_x < XR) &&
                  (pix_y >= 0) && (pix_y < YR);
  assign pix_addr = 17'(pix_y[8:0]) * 17'(X_RES) + 17'(pix_x[8:0]);
  assign nxt_ox = (cur_ox == RS) ? -RS : cur_ox + 11'sd1;
  assign nxt_oy = (cur_ox == RS) ? cur_oy + 11'sd1 : cur_oy;

  always_comb begin
    state_d = state_q;
    pend_d = pend_q;
    ca_d = ca_q;
    cnt_d = cnt_q;
    bx_d = bx_q;
    by_d = by_q;
    ox_d = ox_q;
    oy_d = oy_q;
    bc_d = bc_q;
    we_d = 1'b0;
    addr_d = '0;
    din_d = '0;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (clr_eff) begin
          state_d = S_CLEAR;
          pend_d = 1'b0;
          we_d = 1'b1;
          din_d = CLEAR_COLOR;
          busy_d = 1'b1;
          ca_d = 17'd1;
        end else if (t_go) begin
          state_d = S_BRUSH;
          bx_d = cur_bx;
          by_d = cur_by;
          bc_d = cur_c;
          ox_d = nxt_ox;
          oy_d = nxt_oy;
          cnt_d = 6'd1;
          we_d = in_rng;
          addr_d = in_rng ? pix_addr : '0;
          din_d = in_rng ? cur_c : '0;
        end else if (h_go) begin
          we_d = in_rng;
          addr_d = in_rng ? pix_addr : '0;
          din_d = in_rng ? cur_c : '0;
        end
      end
      S_CLEAR: begin
        if (ca_q == 17'(TOTAL)) begin
          state_d = S_IDLE;
          done_d = 1'b1;
        end else begin
          we_d = 1'b1;
          addr_d = ca_q;
          din_d = CLEAR_COLOR;
          busy_d = 1'b1;
          ca_d = ca_q + 17'd1;
        end
      end
      S_BRUSH: begin
        // last cell is still on the outputs in the drain cycle
        if (cnt_q == 6'(B2)) begin
          state_d = S_IDLE;
        end else begin
          ox_d = nxt_ox;
          oy_d = nxt_oy;
          cnt_d = cnt_q + 6'd1;
          we_d = in_rng;
          addr_d = in_rng ? pix_addr : '0;
          din_d = in_rng ? cur_c : '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge cclk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend_q <= 1'b1;
      ca_q <= '0;
      cnt_q <= '0;
      bx_q <= '0;
      by_q <= '0;
      ox_q <= '0;
      oy_q <= '0;
      bc_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      din_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      ca_q <= ca_d;
      cnt_q <= cnt_d;
      bx_q <= bx_d;
      by_q <= by_d;
      ox_q <= ox_d;
      oy_q <= oy_d;
      bc_q <= bc_d;
      we_q <= we_d;
      addr_q <= addr_d;
      din_q <= din_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign vram_we = we_q;
  assign vram_addr = addr_q;
  assign vram_din = din_q;
  assign clear_busy = busy_q;
  assign clear_done = done_q;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Bench for vram_write_scheduler on a reduced 40x24 screen.
// A queue of expected output beats is checked every cycle.
module tb_vram_write_scheduler;
  localparam int XR = 40;
  localparam int YR = 24;
  localparam int TOTAL = XR * YR;
  localparam int BR = 3;
  localparam int R = (BR - 1) / 2;
  localparam logic [8:0] CC = 9'h003;

  logic cclk = 1'b0;
  logic rst = 1'b1;
  logic clear_req = 1'b0;
  logic clear_busy, clear_done;
  logic touch_valid = 1'b0;
  logic [8:0] touch_x = '0, touch_y = '0, touch_color = '0;
  logic touch_ready;
  logic host_valid = 1'b0;
  logic [8:0] host_x = '0, host_y = '0, host_data = '0;
  logic host_ready;
  logic vram_we;
  logic [16:0] vram_addr;
  logic [8:0] vram_din;

  vram_write_scheduler #(
    .X_RES(XR), .Y_RES(YR), .BITS_PER_PIXEL(9),
    .CLEAR_COLOR(CC), .BRUSH(BR)
  ) dut (
    .cclk(cclk), .rst(rst),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .clear_done(clear_done),
    .touch_valid(touch_valid), .touch_x(touch_x),
    .touch_y(touch_y), .touch_color(touch_color),
    .touch_ready(touch_ready),
    .host_valid(host_valid), .host_x(host_x),
    .host_y(host_y), .host_data(host_data),
    .host_ready(host_ready),
    .vram_we(vram_we), .vram_addr(vram_addr),
    .vram_din(vram_din)
  );

  always #5 cclk = ~cclk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int wlog[$];
  int dlog[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic we;
    logic [16:0] a;
    logic [8:0] d;
    logic busy;
    logic done;
  } beat_t;

  beat_t q[$];
  beat_t cur = '0;
  bit pend = 1'b1;

  function automatic beat_t pix(input int x, input int y,
                                input logic [8:0] c);
    beat_t b;
    b = '0;
    if (x >= 0 && x < XR && y >= 0 && y < YR) begin
      b.we = 1'b1;
      b.a = 17'(y * XR + x);
      b.d = c;
    end
    return b;
  endfunction

  // compare + model, once per cycle on the falling edge
  initial begin
    bit idle_m, tr_m, hr_m;
    beat_t b;
    @(posedge cclk);
    forever begin
      @(negedge cclk);
      chk("we", vram_we, cur.we);
      chk("addr", vram_addr, cur.a);
      chk("din", vram_din, cur.d);
      chk("busy", clear_busy, cur.busy);
      chk("done", clear_done, cur.done);
      idle_m = !rst && q.size() == 0;
      tr_m = idle_m && !(clear_req || pend);
      hr_m = tr_m && !touch_valid;
      chk("touch_ready", touch_ready, tr_m);
      chk("host_ready", host_ready, hr_m);
      if (vram_we === 1'b1) begin
        wlog.push_back(int'(vram_addr));
        dlog.push_back(int'(vram_din));
      end
      if (clear_done === 1'b1) done_cnt++;
      if (rst) begin
        q.delete();
        pend = 1'b1;
        cur = '0;
      end else begin
        if (idle_m) begin
          if (clear_req || pend) begin
            pend = 1'b0;
            for (int i = 0; i < TOTAL; i++) begin
              b = '0;
              b.we = 1'b1;
              b.a = 17'(i);
              b.d = CC;
              b.busy = 1'b1;
              q.push_back(b);
            end
            b = '0;
            b.done = 1'b1;
            q.push_back(b);
          end else if (touch_valid) begin
            for (int dy = -R; dy <= R; dy++)
              for (int dx = -R; dx <= R; dx++)
                q.push_back(pix(int'(touch_x) + dx,
                                int'(touch_y) + dy, touch_color));
            q.push_back('0);
          end else if (host_valid) begin
            q.push_back(pix(int'(host_x), int'(host_y), host_data));
          end
        end
        cur = (q.size() != 0) ? q.pop_front() : '0;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge cclk);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (touch_ready !== 1'b1 && k < 3000) begin
      step();
      k++;
    end
    if (k >= 3000) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_done(input int base);
    int k;
    k = 0;
    while (done_cnt == base && k < TOTAL + 100) begin
      step();
      k++;
    end
    chk("done_timeout", done_cnt, base + 1);
  endtask

  task automatic brush(input int x, input int y,
                       input logic [8:0] c);
    wait_idle();
    wlog.delete();
    dlog.delete();
    touch_x = 9'(x);
    touch_y = 9'(y);
    touch_color = c;
    touch_valid = 1'b1;
    step();
    touch_valid = 1'b0;
    step(BR * BR + 3);
  endtask

  initial begin
    int ea[$];
    int n0;
    step(3);
    chk("rst_we", vram_we, 0);
    chk("rst_addr", vram_addr, 0);
    chk("rst_din", vram_din, 0);
    chk("rst_busy", clear_busy, 0);
    chk("rst_done", clear_done, 0);
    chk("rst_tready", touch_ready, 0);
    chk("rst_hready", host_ready, 0);

    // power-up clear, with ignored re-requests
    wlog.delete();
    dlog.delete();
    rst = 1'b0;
    for (int c = 0; c < TOTAL + 50 && done_cnt == 0; c++) begin
      step();
      clear_req = (c == 100 || c == 500);
    end
    clear_req = 1'b0;
    step(3);
    chk("pu_done_once", done_cnt, 1);
    chk("pu_count", wlog.size(), TOTAL);
    chk("pu_first", wlog[0], 0);
    chk("pu_last", wlog[TOTAL-1], TOTAL - 1);
    chk("pu_din", dlog[10], 32'h003);

    brush(20, 10, 9'h1C0);
    ea = '{379, 380, 381, 419, 420, 421, 459, 460, 461};
    chk("int_n", wlog.size(), 9);
    foreach (ea[i]) if (i < wlog.size()) chk("int_addr", wlog[i], ea[i]);
    chk("int_din", dlog[8], 32'h1C0);

    brush(0, 0, 9'h00F);
    ea = '{0, 1, 40, 41};
    chk("tl_n", wlog.size(), 4);
    foreach (ea[i]) if (i < wlog.size()) chk("tl_addr", wlog[i], ea[i]);

    brush(XR - 1, YR - 1, 9'h0F0);
    ea = '{918, 919, 958, 959};
    chk("br_n", wlog.size(), 4);
    foreach (ea[i]) if (i < wlog.size()) chk("br_addr", wlog[i], ea[i]);

    // all three requests at once: clear, then touch, then host
    wait_idle();
    wlog.delete();
    dlog.delete();
    clear_req = 1'b1;
    touch_valid = 1'b1;
    touch_x = 9'd5;
    touch_y = 9'd5;
    touch_color = 9'h111;
    host_valid = 1'b1;
    host_x = 9'(XR - 1);
    host_y = 9'(YR - 1);
    host_data = 9'h155;
    step();
    clear_req = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (touch_ready) begin
        step();
        touch_valid = 1'b0;
        break;
      end
      step();
    end
    for (int k = 0; k < 100; k++) begin
      if (host_ready) begin
        step();
        host_valid = 1'b0;
        break;
      end
      step();
    end
    touch_valid = 1'b0;
    host_valid = 1'b0;
    step(5);
    chk("arb_n", wlog.size(), TOTAL + 10);
    if (wlog.size() == TOTAL + 10) begin
      chk("arb_touch", wlog[TOTAL], 164);
      chk("arb_host", wlog[TOTAL+9], 959);
      chk("arb_hdin", dlog[TOTAL+9], 32'h155);
    end

    // out-of-range host write is dropped, next one lands
    wait_idle();
    wlog.delete();
    host_valid = 1'b1;
    host_x = 9'(XR);
    host_y = 9'd0;
    step();
    host_x = 9'd1;
    step();
    host_valid = 1'b0;
    step(3);
    chk("host_n", wlog.size(), 1);
    if (wlog.size() > 0) chk("host_addr", wlog[0], 1);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      touch_valid = ($urandom_range(0, 3) == 0);
      host_valid = ($urandom_range(0, 2) == 0);
      clear_req = ($urandom_range(0, 299) == 0);
      touch_x = 9'($urandom_range(0, XR + 2));
      touch_y = 9'($urandom_range(0, YR + 2));
      touch_color = 9'($urandom);
      host_x = 9'($urandom_range(0, XR + 2));
      host_y = 9'($urandom_range(0, YR + 2));
      host_data = 9'($urandom);
      step();
    end
    touch_valid = 1'b0;
    host_valid = 1'b0;
    clear_req = 1'b0;
    wait_idle();

    // reset in the middle of a clear
    wlog.delete();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int k = 0; k < TOTAL && wlog.size() < 500; k++) step();
    rst = 1'b1;
    step();
    chk("mid_rst_we", vram_we, 0);
    chk("mid_rst_busy", clear_busy, 0);
    step();
    n0 = wlog.size();
    rst = 1'b0;
    wait_done(done_cnt);
    step(3);
    chk("rst_clr_n", wlog.size() - n0, TOTAL);
    if (wlog.size() > n0) chk("rst_clr_first", wlog[n0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
